// File: rtl/symbol_reader.sv
// symbol_reader: scans one 16x16 framebuffer cell and classifies it as empty,
// an X symbol, or unrecognised.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 scan request, honoured only when idle
//   x_base, y_base        cell top-left corner, latched when start is accepted
//   rd_data               pixel colour, returned one cycle after rd_en
//   rd_en, rd_x, rd_y     framebuffer read strobe and address (registered)
//   busy                  scan in progress, through the done cycle
//   done                  one-cycle pulse; results valid from this cycle
//   symbol                00 empty, 01 X symbol, 10 unrecognised
//   hit_count             stroke positions that read MATCH_COLOUR
//   stray_count           check positions that read anything but BG_COLOUR
module symbol_reader #(
  parameter logic [2:0] MATCH_COLOUR = 3'b101,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_base,
  input  logic [6:0] y_base,
  input  logic [2:0] rd_data,
  output logic       rd_en,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic       busy,
  output logic       done,
  output logic [1:0] symbol,
  output logic [5:0] hit_count,
  output logic [2:0] stray_count
);

  localparam int unsigned XW     = 8;
  localparam int unsigned YW     = 7;
  localparam int unsigned KW     = 6;
  localparam int unsigned HW     = 6;
  localparam int unsigned SW     = 3;
  localparam int unsigned LAST_K = 35;
  localparam int unsigned N_HIT  = 32;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_X     = 2'b01;
  localparam logic [1:0] SYM_UNREC = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [XW-1:0]   xb_q, xb_d;
  logic [YW-1:0]   yb_q, yb_d;
  logic            rd_en_q, rd_en_d;
  logic [XW-1:0]   rd_x_q, rd_x_d;
  logic [YW-1:0]   rd_y_q, rd_y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      symbol_q, symbol_d;
  logic [HW-1:0]   hit_q, hit_d;
  logic [SW-1:0]   stray_q, stray_d;
  // Read issued last cycle; its data is on rd_data this cycle.
  logic            pend_v_q, pend_v_d;
  logic            pend_stroke_q, pend_stroke_d;

  logic [KW-1:0]   nxt_k;
  logic [7:0]      nxt_off;

  // Cell offset {dx,dy} of scan index k: main diagonal, anti-diagonal, then
  // four off-stroke check points.
  function automatic logic [7:0] offset(input logic [KW-1:0] k);
    logic [7:0] off;
    if (!k[5]) begin
      off = k[4] ? {~k[3:0], k[3:0]} : {k[3:0], k[3:0]};
    end else begin
      case (k[1:0])
        2'd0:    off = {4'd7,  4'd0};
        2'd1:    off = {4'd0,  4'd7};
        2'd2:    off = {4'd15, 4'd8};
        default: off = {4'd8,  4'd15};
      endcase
    end
    return off;
  endfunction

  function automatic logic [1:0] classify(input logic [HW-1:0] hits,
                                          input logic [SW-1:0] strays);
    logic [1:0] s;
    if (hits == HW'(N_HIT) && strays == '0) s = SYM_X;
    else if (hits == '0 && strays == '0)    s = SYM_EMPTY;
    else                                    s = SYM_UNREC;
    return s;
  endfunction

  assign nxt_k   = idx_q + KW'(1);
  assign nxt_off = offset(nxt_k);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      xb_q          <= '0;
      yb_q          <= '0;
      rd_en_q       <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      symbol_q      <= SYM_EMPTY;
      hit_q         <= '0;
      stray_q       <= '0;
      pend_v_q      <= 1'b0;
      pend_stroke_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      xb_q          <= xb_d;
      yb_q          <= yb_d;
      rd_en_q       <= rd_en_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      symbol_q      <= symbol_d;
      hit_q         <= hit_d;
      stray_q       <= stray_d;
      pend_v_q      <= pend_v_d;
      pend_stroke_q <= pend_stroke_d;
    end
  end

  // Next-state, read issue and result accumulation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    xb_d          = xb_q;
    yb_d          = yb_q;
    rd_en_d       = 1'b0;
    rd_x_d        = rd_x_q;
    rd_y_d        = rd_y_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    symbol_d      = symbol_q;
    hit_d         = hit_q;
    stray_d       = stray_q;
    pend_v_d      = rd_en_q;
    pend_stroke_d = ~idx_q[5];

    if (pend_v_q) begin
      if (pend_stroke_q) begin
        if (rd_data == MATCH_COLOUR) hit_d = hit_q + HW'(1);
      end else begin
        if (rd_data != BG_COLOUR) stray_d = stray_q + SW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          xb_d     = x_base;
          yb_d     = y_base;
          idx_d    = '0;
          rd_en_d  = 1'b1;
          rd_x_d   = x_base;
          rd_y_d   = y_base;
          busy_d   = 1'b1;
          hit_d    = '0;
          stray_d  = '0;
          symbol_d = SYM_EMPTY;
        end
      end
      ISSUE: begin
        if (idx_q == KW'(LAST_K)) begin
          state_d = DRAIN;
        end else begin
          idx_d   = nxt_k;
          rd_en_d = 1'b1;
          // Address adds wrap silently at the framebuffer edge.
          rd_x_d  = xb_q + XW'(nxt_off[7:4]);
          rd_y_d  = yb_q + YW'(nxt_off[3:0]);
        end
      end
      DRAIN: begin
        // Last pixel lands this cycle, so classify the updated counts.
        state_d  = DONE;
        done_d   = 1'b1;
        symbol_d = classify(hit_d, stray_d);
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign symbol      = symbol_q;
  assign hit_count   = hit_q;
  assign stray_count = stray_q;

endmodule

// File: tb/tb_symbol_reader.sv
// Bench for symbol_reader: framebuffer model, randomized scans, scoreboard
// of expected read addresses and results checked by a separate monitor.
module tb_symbol_reader;

  localparam logic [2:0] MATCH = 3'b101;
  localparam logic [2:0] BG    = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_base = '0;
  logic [6:0] y_base = '0;
  logic [2:0] rd_data = '0;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       busy;
  logic       done;
  logic [1:0] symbol;
  logic [5:0] hit_count;
  logic [2:0] stray_count;

  symbol_reader #(.MATCH_COLOUR(MATCH), .BG_COLOUR(BG)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x_base(x_base),
    .y_base(y_base), .rd_data(rd_data), .rd_en(rd_en), .rd_x(rd_x),
    .rd_y(rd_y), .busy(busy), .done(done), .symbol(symbol),
    .hit_count(hit_count), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  logic [2:0] fb [256][128];

  // Framebuffer: data one cycle after the read, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= fb[rd_x][rd_y];
    else       rd_data <= 3'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int hit; int stray; int sym; int done_cyc;} res_t;
  res_t res_q[$];
  int   ax_q[$];
  int   ay_q[$];

  int checks = 0;
  int errors = 0;
  int s_cyc = -1000;
  int last_hit = 0, last_stray = 0, last_sym = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fill(input logic [2:0] c);
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++) fb[x][y] = c;
  endtask

  task automatic fill_rand();
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++) begin
        case ($urandom_range(0, 3))
          0, 1:    fb[x][y] = BG;
          2:       fb[x][y] = MATCH;
          default: fb[x][y] = 3'($urandom);
        endcase
      end
  endtask

  task automatic draw_x(input int x, input int y);
    for (int i = 0; i < 16; i++) begin
      fb[(x + i) % 256][(y + i) % 128]      = MATCH;
      fb[(x + 15 - i) % 256][(y + i) % 128] = MATCH;
    end
  endtask

  // Reference: scan order and classification straight from the cell geometry.
  task automatic expect_scan(input int x, input int y, input int s);
    int dx, dy, hits, strays, px, py;
    res_t r;
    int cx[4] = '{7, 0, 15, 8};
    int cy[4] = '{0, 7, 8, 15};
    hits = 0;
    strays = 0;
    for (int k = 0; k < 36; k++) begin
      if (k < 16)      begin dx = k;      dy = k;      end
      else if (k < 32) begin dx = 31 - k; dy = k - 16; end
      else             begin dx = cx[k-32]; dy = cy[k-32]; end
      px = (x + dx) % 256;
      py = (y + dy) % 128;
      ax_q.push_back(px);
      ay_q.push_back(py);
      if (k < 32) begin
        if (fb[px][py] == MATCH) hits++;
      end else if (fb[px][py] != BG) strays++;
    end
    r.hit = hits;
    r.stray = strays;
    r.sym = (hits == 32 && strays == 0) ? 1 : (hits == 0 && strays == 0) ? 0 : 2;
    r.done_cyc = s + 38;
    res_q.push_back(r);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs",
            int'({rd_en, busy, done, symbol, hit_count, stray_count, rd_x, rd_y}), 0);
    end else begin
      check("busy", int'(busy), int'(cyc > s_cyc && cyc <= s_cyc + 38));
      if (cyc == s_cyc + 1) begin
        check("hit_clear", int'(hit_count), 0);
        check("stray_clear", int'(stray_count), 0);
      end
      if (rd_en) begin
        if (ax_q.size() == 0) begin
          check("unexpected_rd_en", 1, 0);
        end else begin
          check("rd_x", int'(rd_x), ax_q.pop_front());
          check("rd_y", int'(rd_y), ay_q.pop_front());
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("done_cycle", cyc, r.done_cyc);
          check("hit_count", int'(hit_count), r.hit);
          check("stray_count", int'(stray_count), r.stray);
          check("symbol", int'(symbol), r.sym);
          last_hit = r.hit;
          last_stray = r.stray;
          last_sym = r.sym;
        end
      end else if (!busy) begin
        check("hold_hit", int'(hit_count), last_hit);
        check("hold_stray", int'(stray_count), last_stray);
        check("hold_symbol", int'(symbol), last_sym);
      end
    end
  end

  // One scan with start noise while busy; b2b raises start in the done cycle,
  // so the caller must start another scan right after.
  task automatic do_scan(input int x, input int y, input bit b2b);
    @(negedge clk);
    start = 1'b1;
    x_base = 8'(x);
    y_base = 7'(y);
    s_cyc = cyc;
    expect_scan(x, y, cyc);
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      x_base = 8'($urandom);
      y_base = 7'($urandom);
      if (c == 38) start = b2b;
      else         start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    fill(BG);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(BG); draw_x(40, 30);
    do_scan(40, 30, 1'b0);

    fill(BG);
    do_scan(17, 99, 1'b0);

    fill(MATCH);
    do_scan(200, 5, 1'b0);

    fill(BG); draw_x(40, 30); fb[45][35] = BG;
    do_scan(40, 30, 1'b1);

    fill(BG); draw_x(250, 120);
    do_scan(250, 120, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int x, y;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 127);
      fill_rand();
      if (n % 2 == 0) draw_x(x, y);
      do_scan(x, y, 1'b0);
    end

    // Abort a scan with reset on cycle 20.
    fill(BG); draw_x(10, 10);
    @(negedge clk);
    start = 1'b1;
    x_base = 8'd10;
    y_base = 7'd10;
    s_cyc = cyc;
    expect_scan(10, 10, cyc);
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    s_cyc = -1000;
    ax_q.delete();
    ay_q.delete();
    res_q.delete();
    last_hit = 0;
    last_stray = 0;
    last_sym = 0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    do_scan(10, 10, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", res_q.size() + ax_q.size() + ay_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
